// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - opcodes, request kinds and loader FSM states shared with the control unit
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  typedef enum logic [1:0] {
    KIND_R   = 2'd0,
    KIND_LW  = 2'd1,
    KIND_SW  = 2'd2,
    KIND_BEQ = 2'd3
  } req_kind_t;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE   = 2'd0;
  localparam state_t S_ACTIVE = 2'd1;
  localparam state_t S_PAD    = 2'd2;
  localparam state_t S_DONE   = 2'd3;

endpackage

// File: rtl/instr_encode.sv
// rtl/instr_encode.sv - combinational encode of a symbolic request into a 32-bit MIPS word
module instr_encode
  import mips_pkg::*;
(
  input  logic [1:0]  kind,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [5:0]  funct,
  input  logic [15:0] imm,
  output logic [31:0] word
);

  // Fields a format does not carry are dropped, never merged in.
  always_comb begin
    word = 32'h0000_0000;
    case (req_kind_t'(kind))
      KIND_R:   word = {OP_RTYPE, rs, rt, rd, shamt, funct};
      KIND_LW:  word = {OP_LW, rs, rt, imm};
      KIND_SW:  word = {OP_SW, rs, rt, imm};
      KIND_BEQ: word = {OP_BEQ, rs, rt, imm};
      default:  word = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// rtl/instr_encoder_loader.sv - encodes requests and loads them into instruction memory; INSTR_ENC_NOP_PAD_EN adds NOP padding
module instr_encoder_loader
  import mips_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DEPTH   = 256,
  parameter int NOP_PAD = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              finish,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_kind,
  input  logic [4:0]        req_rs,
  input  logic [4:0]        req_rt,
  input  logic [4:0]        req_rd,
  input  logic [4:0]        req_shamt,
  input  logic [5:0]        req_funct,
  input  logic [15:0]       req_imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  input  logic              imem_stall,
  output logic [ADDR_W:0]   word_count,
  output logic              full,
  output logic              done
);

  localparam logic [ADDR_W:0]   DEPTH_W   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   NOP_W     = (ADDR_W+1)'(NOP_PAD);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   count;
  logic [ADDR_W:0]   pad_left;
  logic              we_q;
  logic [31:0]       wdata_q;
  logic              fin_q;

  logic [31:0]       enc_word;
  logic              commit;
  logic              accept;
  logic              full_pending;
  logic              ready;
  logic [ADDR_W:0]   remain;
  logic [ADDR_W:0]   pad_init;

  instr_encode u_encode (
    .kind  (req_kind),
    .rs    (req_rs),
    .rt    (req_rt),
    .rd    (req_rd),
    .shamt (req_shamt),
    .funct (req_funct),
    .imm   (req_imm),
    .word  (enc_word)
  );

  assign commit       = we_q && !imem_stall;
  assign full_pending = (count + {{ADDR_W{1'b0}}, we_q}) == DEPTH_W;
  // finish wins over a same-cycle request, so it also masks ready.
  assign ready        = (state == S_ACTIVE) && !fin_q && !finish && !full_pending &&
                        (!we_q || !imem_stall);
  assign accept       = req_valid && ready;
  assign remain       = DEPTH_W - count;
  assign pad_init     = (remain < NOP_W) ? remain : NOP_W;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      addr     <= '0;
      count    <= '0;
      pad_left <= '0;
      we_q     <= 1'b0;
      wdata_q  <= 32'h0000_0000;
      fin_q    <= 1'b0;
    end else begin
      if (commit) begin
        count <= count + (ADDR_W+1)'(1);
        if (addr != LAST_ADDR) addr <= addr + ADDR_W'(1);
      end
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state <= S_ACTIVE;
            addr  <= '0;
            count <= '0;
            fin_q <= 1'b0;
          end
        end
        S_ACTIVE: begin
          if (finish) fin_q <= 1'b1;
          if (accept) begin
            we_q    <= 1'b1;
            wdata_q <= enc_word;
          end else if (commit) begin
            we_q <= 1'b0;
          end
          if (!we_q && count == DEPTH_W) begin
            state <= S_DONE;
          end else if (!we_q && fin_q) begin
            pad_left <= pad_init;
`ifdef INSTR_ENC_NOP_PAD_EN
            state    <= S_PAD;
`else
            state    <= S_DONE;
`endif
          end
        end
        S_PAD: begin
          if (pad_left != '0 && (!we_q || commit)) begin
            we_q     <= 1'b1;
            wdata_q  <= 32'h0000_0000;
            pad_left <= pad_left - (ADDR_W+1)'(1);
          end else if (commit) begin
            we_q <= 1'b0;
          end else if (!we_q && pad_left == '0) begin
            state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = ready;
  assign imem_we    = we_q;
  assign imem_addr  = addr;
  assign imem_wdata = wdata_q;
  assign word_count = count;
  assign full       = (count == DEPTH_W);
  assign done       = (state == S_DONE);

endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb/tb_instr_encoder_loader.sv - scoreboard bench for instr_encoder_loader (DEPTH=256 and DEPTH=4 instances)
module tb_instr_encoder_loader;

`ifdef INSTR_ENC_NOP_PAD_EN
  localparam int PADS = 4;
`else
  localparam int PADS = 0;
`endif

  logic        clk = 1'b0;
  logic        reset, start, finish, req_valid, imem_stall;
  logic [1:0]  req_kind;
  logic [4:0]  req_rs, req_rt, req_rd, req_shamt;
  logic [5:0]  req_funct;
  logic [15:0] req_imm;

  logic        req_ready, imem_we, full, done;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [8:0]  word_count;
  logic        ready4, we4, full4, done4;
  logic [7:0]  addr4;
  logic [31:0] wdata4;
  logic [8:0]  wc4;

  int n_checks = 0;
  int n_errors = 0;
  logic [39:0] q[$];
  logic [39:0] q4[$];
  int exp_n  = 0;
  int exp_n4 = 0;

  always #5 clk = ~clk;

  instr_encoder_loader dut (
    .clk(clk), .reset(reset), .start(start), .finish(finish),
    .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind),
    .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd), .req_shamt(req_shamt),
    .req_funct(req_funct), .req_imm(req_imm), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .imem_stall(imem_stall),
    .word_count(word_count), .full(full), .done(done)
  );

  instr_encoder_loader #(.ADDR_W(8), .DEPTH(4), .NOP_PAD(4)) dut4 (
    .clk(clk), .reset(reset), .start(start), .finish(finish),
    .req_valid(req_valid), .req_ready(ready4), .req_kind(req_kind),
    .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd), .req_shamt(req_shamt),
    .req_funct(req_funct), .req_imm(req_imm), .imem_we(we4),
    .imem_addr(addr4), .imem_wdata(wdata4), .imem_stall(imem_stall),
    .word_count(wc4), .full(full4), .done(done4)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [1:0] k, input logic [4:0] rs, rt, rd, sh,
                                      input logic [5:0] fn, input logic [15:0] imm);
    case (k)
      2'd0:    return {6'b000000, rs, rt, rd, sh, fn};
      2'd1:    return {6'b100011, rs, rt, imm};
      2'd2:    return {6'b101011, rs, rt, imm};
      default: return {6'b000100, rs, rt, imm};
    endcase
  endfunction

  always @(negedge clk) begin
    logic [39:0] e;
    if (imem_we && !imem_stall) begin
      if (q.size() == 0) check("extra_write", 1, 0);
      else begin
        e = q.pop_front();
        check("wr_addr", imem_addr, e[39:32]);
        check("wr_data", imem_wdata, e[31:0]);
      end
    end
    if (we4 && !imem_stall) begin
      if (q4.size() == 0) check("extra_write4", 1, 0);
      else begin
        e = q4.pop_front();
        check("wr_addr4", addr4, e[39:32]);
        check("wr_data4", wdata4, e[31:0]);
      end
    end
  end

  task automatic send(input logic [1:0] k, input logic [4:0] rs, rt, rd, sh,
                      input logic [5:0] fn, input logic [15:0] imm, output int waited);
    logic [31:0] w;
    bit ok;
    w = enc(k, rs, rt, rd, sh, fn, imm);
    ok = 0; waited = 0;
    req_kind = k; req_rs = rs; req_rt = rt; req_rd = rd;
    req_shamt = sh; req_funct = fn; req_imm = imm; req_valid = 1'b1;
    while (!ok && waited < 20) begin
      @(negedge clk);
      if (ready4) begin q4.push_back({8'(exp_n4), w}); exp_n4++; end
      if (req_ready) begin q.push_back({8'(exp_n), w}); exp_n++; ok = 1; end
      @(posedge clk); #1;
      if (!ok) waited++;
    end
    req_valid = 1'b0;
    if (!ok) check("send_timeout", 0, 1);
  endtask

  task automatic do_start();
    exp_n = 0; exp_n4 = 0;
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
  endtask

  task automatic do_finish(input bit with_valid);
    int p;
    finish = 1'b1;
    if (with_valid) begin
      req_valid = 1'b1;
      @(negedge clk);
      check("finish_wins", req_ready, 0);
      @(posedge clk); #1;
      req_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
    end
    finish = 1'b0;
    p = (256 - exp_n < PADS) ? 256 - exp_n : PADS;
    for (int i = 0; i < p; i++) begin q.push_back({8'(exp_n), 32'h0}); exp_n++; end
    p = (4 - exp_n4 < PADS) ? 4 - exp_n4 : PADS;
    for (int i = 0; i < p; i++) begin q4.push_back({8'(exp_n4), 32'h0}); exp_n4++; end
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 100) begin @(negedge clk); n++; end
    if (!done) check("done_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    q.delete(); q4.delete(); exp_n = 0; exp_n4 = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    reset = 1'b0; start = 1'b0; finish = 1'b0; req_valid = 1'b0; imem_stall = 1'b0;
    req_kind = '0; req_rs = '0; req_rt = '0; req_rd = '0;
    req_shamt = '0; req_funct = '0; req_imm = '0;
    do_reset();
    @(negedge clk);
    check("rst_we", imem_we, 0);
    check("rst_ready", req_ready, 0);
    check("rst_count", word_count, 0);
    check("rst_done", done, 0);
    check("rst_full", full, 0);
    @(posedge clk); #1;

    // single R word: latency and encoding
    do_start();
    send(2'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'hFFFF, w);
    @(negedge clk);
    check("lat_we", imem_we, 1);
    check("lat_addr", imem_addr, 0);
    check("lat_data", imem_wdata, 32'h0022_1820);
    @(negedge clk);
    check("r_count", word_count, 1);
    @(posedge clk); #1;
    do_finish(0);
    wait_done();
    check("r_q_empty", q.size(), 0);

    // lw/sw/beq back-to-back
    do_start();
    send(2'd1, 5'd1, 5'd2, 5'd0, 5'd0, 6'h0, 16'h0004, w);
    send(2'd2, 5'd1, 5'd2, 5'd0, 5'd0, 6'h0, 16'h0008, w);
    check("b2b_wait_sw", w, 0);
    send(2'd3, 5'd1, 5'd2, 5'd7, 5'd7, 6'h3F, 16'hFFFF, w);
    check("b2b_wait_beq", w, 0);
    check("b2b_words", enc(2'd3, 5'd1, 5'd2, 5'd0, 5'd0, 6'h0, 16'hFFFF), 32'h1022_FFFF);
    do_finish(0);
    wait_done();
    check("b2b_count", word_count, 3 + PADS);
    check("b2b_q_empty", q.size(), 0);

    // stall mid-stream
    do_start();
    send(2'd0, 5'd4, 5'd5, 5'd6, 5'd2, 6'h2A, 16'h0, w);
    imem_stall = 1'b1;
    req_kind = 2'd1; req_rs = 5'd9; req_rt = 5'd10; req_imm = 16'h0010; req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_we", imem_we, 1);
      check("stall_addr", imem_addr, 0);
      check("stall_data", imem_wdata, {6'b0, 5'd4, 5'd5, 5'd6, 5'd2, 6'h2A});
      check("stall_ready", req_ready, 0);
      @(posedge clk); #1;
    end
    imem_stall = 1'b0;
    send(2'd1, 5'd9, 5'd10, 5'd0, 5'd0, 6'h0, 16'h0010, w);
    @(negedge clk);
    @(negedge clk);
    check("stall_count", word_count, 2);
    @(posedge clk); #1;
    // finish together with a request: finish wins
    do_finish(1);
    wait_done();
    check("fin_count", word_count, 2 + PADS);
    check("fin_done", done, 1);
    check("fin_q_empty", q.size(), 0);

    // full on the DEPTH=4 instance
    do_start();
    for (int i = 0; i < 6; i++) send(2'd2, 5'(i), 5'(i + 1), 5'd0, 5'd0, 6'h0, 16'(i * 4), w);
    @(negedge clk);
    check("full4_full", full4, 1);
    check("full4_done", done4, 1);
    check("full4_ready", ready4, 0);
    check("full4_count", wc4, 4);
    check("full4_addr", addr4, 3);
    @(posedge clk); #1;
    do_finish(0);
    wait_done();
    check("full_main_count", word_count, 6 + PADS);
    check("full4_q_empty", q4.size(), 0);

    // reset while a write is pending
    do_start();
    send(2'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, w);
    check("rst_mid_we_pre", imem_we, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    q.delete(); q4.delete(); exp_n = 0; exp_n4 = 0;
    @(negedge clk);
    check("rst_mid_we", imem_we, 0);
    check("rst_mid_addr", imem_addr, 0);
    check("rst_mid_data", imem_wdata, 0);
    check("rst_mid_count", word_count, 0);
    check("rst_mid_ready", req_ready, 0);
    check("rst_mid_done", done, 0);
    @(posedge clk); #1;
    do_start();
    send(2'd1, 5'd3, 5'd4, 5'd0, 5'd0, 6'h0, 16'h00AA, w);
    @(negedge clk);
    check("rst_new_addr", imem_addr, 0);
    @(posedge clk); #1;
    do_finish(0);
    wait_done();
    check("rst_new_count", word_count, 1 + PADS);
    check("end_q_empty", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
